// File: rtl/minesweeper_board_if.sv
// Processor/display bus of the minesweeper board store.
// The processor (master) drives address, write data and control; the board
// (slave) returns the registered cell words, the adjacency result and busy.
interface minesweeper_board_if;
    logic [7:0] position;
    logic [0:5] wdata;
    logic       we;
    logic       rstBoard;
    logic [0:5] rdata;
    logic [2:0] adjBombs;
    logic       adjValid;
    logic       busy;
    logic [7:0] vidAddr;
    logic [0:5] vidData;

    modport master (
        output position, wdata, we, rstBoard, vidAddr,
        input  rdata, adjBombs, adjValid, busy, vidData
    );

    modport slave (
        input  position, wdata, we, rstBoard, vidAddr,
        output rdata, adjBombs, adjValid, busy, vidData
    );
endinterface

// File: rtl/minesweeper_board.sv
// Board-state store for the 16x16 minesweeper grid.
// Holds 256 six-bit cells (bit0 bomb, bit1 covered, bit2 flagged, bits3:5
// revealed number), runs the new-game clear sweep, serves a processor and a
// display read port, and counts bombs around the current position with a
// one-neighbour-per-cycle scan.
module minesweeper_board (
    input  logic               clk,
    input  logic               reset,
    minesweeper_board_if.slave bus
);

    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_t;

    typedef enum logic [1:0] {
        ADJ_IDLE = 2'd0,
        ADJ_SCAN = 2'd1,
        ADJ_DONE = 2'd2
    } adj_state_t;

    localparam logic [0:5] CELL_CLEAR = 6'b010000;

    // Eight-or-more neighbouring bombs are reported as 7.
    function automatic logic [2:0] sat_count(input logic [3:0] acc);
        logic [2:0] result;
        if (acc > 4'd7) begin
            result = 3'd7;
        end else begin
            result = acc[2:0];
        end
        return result;
    endfunction

    logic [0:5]  cells_r [0:255];
    clr_state_t  clr_state_r;
    logic [7:0]  clr_cnt_r;
    logic        rst_d_r;
    logic [0:5]  rdata_r;
    logic [0:5]  vid_data_r;
    adj_state_t  adj_state_r;
    logic [7:0]  scan_pos_r;
    logic [2:0]  scan_k_r;
    logic [3:0]  acc_r;
    logic [2:0]  adj_bombs_r;
    logic        adj_valid_r;

    logic        sweep_start_s;
    logic        busy_s;
    logic        sweep_last_s;
    logic        wr_accept_s;
    logic        pos_change_s;
    logic [3:0]  row_s;
    logic [3:0]  col_s;
    logic [3:0]  nb_row_s;
    logic [3:0]  nb_col_s;
    logic        nb_on_grid_s;
    logic        nb_bomb_s;

    // A sweep request wins over a same-cycle write; writes are locked out while sweeping.
    always_comb begin
        sweep_start_s = reset | bus.rstBoard;
        busy_s        = (clr_state_r == CLR_RUN);
        sweep_last_s  = busy_s & (clr_cnt_r == 8'd255) & ~sweep_start_s;
        wr_accept_s   = bus.we & ~busy_s & ~sweep_start_s;
        pos_change_s  = (bus.position != scan_pos_r);
    end

    // Neighbour k of the latched position in NW, N, NE, W, E, SW, S, SE order, masked at the grid edges.
    always_comb begin
        row_s        = scan_pos_r[7:4];
        col_s        = scan_pos_r[3:0];
        nb_row_s     = row_s;
        nb_col_s     = col_s;
        nb_on_grid_s = 1'b0;
        case (scan_k_r)
            3'd0: begin
                nb_row_s     = row_s - 4'd1;
                nb_col_s     = col_s - 4'd1;
                nb_on_grid_s = (row_s != 4'd0) && (col_s != 4'd0);
            end
            3'd1: begin
                nb_row_s     = row_s - 4'd1;
                nb_on_grid_s = (row_s != 4'd0);
            end
            3'd2: begin
                nb_row_s     = row_s - 4'd1;
                nb_col_s     = col_s + 4'd1;
                nb_on_grid_s = (row_s != 4'd0) && (col_s != 4'd15);
            end
            3'd3: begin
                nb_col_s     = col_s - 4'd1;
                nb_on_grid_s = (col_s != 4'd0);
            end
            3'd4: begin
                nb_col_s     = col_s + 4'd1;
                nb_on_grid_s = (col_s != 4'd15);
            end
            3'd5: begin
                nb_row_s     = row_s + 4'd1;
                nb_col_s     = col_s - 4'd1;
                nb_on_grid_s = (row_s != 4'd15) && (col_s != 4'd0);
            end
            3'd6: begin
                nb_row_s     = row_s + 4'd1;
                nb_on_grid_s = (row_s != 4'd15);
            end
            3'd7: begin
                nb_row_s     = row_s + 4'd1;
                nb_col_s     = col_s + 4'd1;
                nb_on_grid_s = (row_s != 4'd15) && (col_s != 4'd15);
            end
            default: begin
                nb_on_grid_s = 1'b0;
            end
        endcase
        nb_bomb_s = nb_on_grid_s & cells_r[{nb_row_s, nb_col_s}][0];
    end

    // Cell array: the sweep clears one cell per cycle, otherwise an accepted write lands at position.
    always_ff @(posedge clk) begin
        if (busy_s && !sweep_start_s) begin
            cells_r[clr_cnt_r] <= CELL_CLEAR;
        end else if (wr_accept_s) begin
            cells_r[bus.position] <= bus.wdata;
        end
    end

    // Clear-sweep FSM: a reset or new-game pulse (re)starts the walk from cell 0.
    always_ff @(posedge clk) begin
        if (sweep_start_s) begin
            clr_state_r <= CLR_RUN;
            clr_cnt_r   <= 8'd0;
        end else begin
            case (clr_state_r)
                CLR_RUN: begin
                    clr_cnt_r <= clr_cnt_r + 8'd1;
                    if (clr_cnt_r == 8'd255) begin
                        clr_state_r <= CLR_IDLE;
                    end
                end
                CLR_IDLE: begin
                    clr_cnt_r <= clr_cnt_r;
                end
                default: begin
                    clr_state_r <= CLR_IDLE;
                end
            endcase
        end
    end

    // Registered read ports; held at zero for the reset cycle and the one after it.
    always_ff @(posedge clk) begin
        rst_d_r <= reset;
        if (reset || rst_d_r) begin
            rdata_r    <= 6'b000000;
            vid_data_r <= 6'b000000;
        end else begin
            rdata_r    <= cells_r[bus.position];
            vid_data_r <= cells_r[bus.vidAddr];
        end
    end

    // Adjacency scan FSM: any trigger restarts the count; the result is published on the first DONE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            adj_state_r <= ADJ_IDLE;
            scan_pos_r  <= 8'd0;
            scan_k_r    <= 3'd0;
            acc_r       <= 4'd0;
            adj_bombs_r <= 3'd0;
            adj_valid_r <= 1'b0;
        end else if (sweep_start_s || (busy_s && !sweep_last_s)) begin
            adj_state_r <= ADJ_IDLE;
            adj_valid_r <= 1'b0;
        end else if (sweep_last_s || wr_accept_s || pos_change_s) begin
            adj_state_r <= ADJ_SCAN;
            scan_pos_r  <= bus.position;
            scan_k_r    <= 3'd0;
            acc_r       <= 4'd0;
            adj_valid_r <= 1'b0;
        end else begin
            case (adj_state_r)
                ADJ_SCAN: begin
                    acc_r <= acc_r + {3'b000, nb_bomb_s};
                    if (scan_k_r == 3'd7) begin
                        adj_state_r <= ADJ_DONE;
                    end else begin
                        scan_k_r <= scan_k_r + 3'd1;
                    end
                end
                ADJ_DONE: begin
                    if (!adj_valid_r) begin
                        adj_bombs_r <= sat_count(acc_r);
                        adj_valid_r <= 1'b1;
                    end
                end
                ADJ_IDLE: begin
                    adj_valid_r <= 1'b0;
                end
                default: begin
                    adj_state_r <= ADJ_IDLE;
                    adj_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rdata    = rdata_r;
    assign bus.vidData  = vid_data_r;
    assign bus.adjBombs = adj_bombs_r;
    assign bus.adjValid = adj_valid_r;
    assign bus.busy     = busy_s;

endmodule
